// File: rtl/map_write_arbiter.sv
// Single owner of the 300-tile screen map. Arbitrates three tile writers by
// round-robin during blanking and runs a whole-map clear on request.
module map_write_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blank,
  input  logic [2:0]   req,
  input  logic [26:0]  req_addr,
  input  logic [8:0]   req_data,
  output logic [2:0]   gnt,
  input  logic         clr_req,
  output logic         clr_busy,
  output logic         clr_done,
  output logic         err_oob,
  output logic [899:0] map
);

  localparam logic [8:0] NumTiles = 9'd300;
  localparam logic [8:0] LastTile = 9'd299;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e       r_state, w_state_d;
  logic [1:0]   r_rr, w_rr_d;
  logic [8:0]   r_clr_ptr, w_clr_ptr_d;
  logic [2:0]   r_gnt, w_gnt_d;
  logic         r_err_oob, w_err_oob_d;
  logic         r_clr_done, w_clr_done_d;
  logic [899:0] r_map;

  logic [2:0]   w_elig;
  logic         w_found;
  logic [1:0]   w_sel;
  logic [8:0]   w_sel_addr;
  logic [2:0]   w_sel_data;
  logic         w_wr_en;
  logic [8:0]   w_wr_idx;
  logic [2:0]   w_wr_data;

  // A requester whose grant is high this cycle still shows req; mask it to avoid a double write.
  assign w_elig  = req & ~r_gnt;
  assign w_found = |w_elig;

  // Round-robin pick: first eligible requester at or after the priority pointer.
  always_comb begin
    w_sel = 2'd0;
    case (r_rr)
      2'd1: begin
        if (w_elig[1])      w_sel = 2'd1;
        else if (w_elig[2]) w_sel = 2'd2;
        else                w_sel = 2'd0;
      end
      2'd2: begin
        if (w_elig[2])      w_sel = 2'd2;
        else if (w_elig[0]) w_sel = 2'd0;
        else                w_sel = 2'd1;
      end
      default: begin
        if (w_elig[0])      w_sel = 2'd0;
        else if (w_elig[1]) w_sel = 2'd1;
        else                w_sel = 2'd2;
      end
    endcase
  end

  // Route the selected requester's tile index and code.
  always_comb begin
    w_sel_addr = req_addr[8:0];
    w_sel_data = req_data[2:0];
    case (w_sel)
      2'd1: begin
        w_sel_addr = req_addr[17:9];
        w_sel_data = req_data[5:3];
      end
      2'd2: begin
        w_sel_addr = req_addr[26:18];
        w_sel_data = req_data[8:6];
      end
      default: begin
        w_sel_addr = req_addr[8:0];
        w_sel_data = req_data[2:0];
      end
    endcase
  end

  // Next-state, grant and single map-write port decode.
  always_comb begin
    w_state_d    = r_state;
    w_rr_d       = r_rr;
    w_clr_ptr_d  = r_clr_ptr;
    w_gnt_d      = 3'b000;
    w_err_oob_d  = 1'b0;
    w_clr_done_d = 1'b0;
    w_wr_en      = 1'b0;
    w_wr_idx     = r_clr_ptr;
    w_wr_data    = 3'd0;
    unique case (r_state)
      StIdle: begin
        if (clr_req) begin
          w_state_d   = StClear;
          w_clr_ptr_d = 9'd0;
        end else if (blank && w_found) begin
          w_gnt_d = 3'b001 << w_sel;
          w_rr_d  = (w_sel == 2'd2) ? 2'd0 : w_sel + 2'd1;
          if (w_sel_addr < NumTiles) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = w_sel_addr;
            w_wr_data = w_sel_data;
          end else begin
            w_err_oob_d = 1'b1;
          end
        end
      end
      StClear: begin
        if (blank) begin
          w_wr_en = 1'b1;
          if (r_clr_ptr == LastTile) begin
            w_state_d    = StIdle;
            w_clr_done_d = 1'b1;
            w_clr_ptr_d  = 9'd0;
          end else begin
            w_clr_ptr_d = r_clr_ptr + 9'd1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_rr       <= 2'd0;
      r_clr_ptr  <= 9'd0;
      r_gnt      <= 3'b000;
      r_err_oob  <= 1'b0;
      r_clr_done <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_rr       <= w_rr_d;
      r_clr_ptr  <= w_clr_ptr_d;
      r_gnt      <= w_gnt_d;
      r_err_oob  <= w_err_oob_d;
      r_clr_done <= w_clr_done_d;
    end
  end

  // Tile map storage: at most one tile written per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_map <= '0;
    end else if (w_wr_en) begin
      for (int i = 0; i < 300; i++) begin
        if (w_wr_idx == 9'(i)) r_map[3*i +: 3] <= w_wr_data;
      end
    end
  end

  assign gnt      = r_gnt;
  assign clr_busy = (r_state == StClear);
  assign clr_done = r_clr_done;
  assign err_oob  = r_err_oob;
  assign map      = r_map;

endmodule

// File: tb/tb_map_write_arbiter.sv
// Bench for map_write_arbiter: vector table, directed corner sequences and
// constrained-random traffic checked against a tile-array reference model.
module tb_map_write_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         blank;
  logic [2:0]   req;
  logic [26:0]  req_addr;
  logic [8:0]   req_data;
  logic         clr_req;
  logic [2:0]   gnt;
  logic         clr_busy;
  logic         clr_done;
  logic         err_oob;
  logic [899:0] map;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state
  logic [2:0] m_tile [300];
  logic [2:0] m_gnt;
  logic       m_err;
  logic       m_done;
  logic       m_busy;
  int         m_rr;
  int         m_cptr;

  typedef struct {
    logic        blank;
    logic [2:0]  req;
    logic [26:0] addr;
    logic [8:0]  data;
    logic [2:0]  gnt;
    logic        err;
  } vec_t;

  vec_t tbl [12];

  map_write_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .blank    (blank),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .gnt      (gnt),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .err_oob  (err_oob),
    .map      (map)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  function automatic logic [8:0] get_addr(int k);
    return req_addr[9*k +: 9];
  endfunction

  function automatic logic [2:0] get_data(int k);
    return req_data[3*k +: 3];
  endfunction

  task automatic model_reset();
    foreach (m_tile[i]) m_tile[i] = 3'd0;
    m_gnt  = 3'b000;
    m_err  = 1'b0;
    m_done = 1'b0;
    m_busy = 1'b0;
    m_rr   = 0;
    m_cptr = 0;
  endtask

  // One rising edge of the specified behaviour, using the inputs present at that edge.
  task automatic model_edge();
    logic [2:0] prev;
    int         pick;
    logic [8:0] a;
    prev   = m_gnt;
    pick   = -1;
    m_gnt  = 3'b000;
    m_err  = 1'b0;
    m_done = 1'b0;
    if (!m_busy) begin
      if (clr_req) begin
        m_busy = 1'b1;
        m_cptr = 0;
      end else if (blank) begin
        for (int i = 0; i < 3; i++) begin
          int k;
          k = (m_rr + i) % 3;
          if (pick < 0 && req[k] && !prev[k]) pick = k;
        end
        if (pick >= 0) begin
          m_gnt[pick] = 1'b1;
          m_rr = (pick + 1) % 3;
          a = get_addr(pick);
          if (a < 9'd300) m_tile[a] = get_data(pick);
          else            m_err = 1'b1;
        end
      end
    end else if (blank) begin
      m_tile[m_cptr] = 3'd0;
      if (m_cptr == 299) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_cptr = 0;
      end else begin
        m_cptr++;
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_map(string name);
    logic [899:0] e;
    int bad;
    bad = -1;
    for (int i = 0; i < 300; i++) e[3*i +: 3] = m_tile[i];
    n_vec++;
    if (map !== e) begin
      n_fail++;
      for (int i = 0; i < 300; i++) begin
        if (bad < 0 && map[3*i +: 3] !== m_tile[i]) bad = i;
      end
      if (bad < 0) bad = 0;
      $display("FAIL %s: tile %0d got %0h want %0h", name, bad, map[3*bad +: 3], m_tile[bad]);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, " gnt"}, 32'(gnt), 32'(m_gnt));
    chk({tag, " err_oob"}, 32'(err_oob), 32'(m_err));
    chk({tag, " clr_busy"}, 32'(clr_busy), 32'(m_busy));
    chk({tag, " clr_done"}, 32'(clr_done), 32'(m_done));
    chk_map({tag, " map"});
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Reset is applied one unit after a check point, i.e. well away from the clock edge.
  task automatic pulse_reset(string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int n0;
    int busy_samples;
    int done_cnt;
    logic [899:0] tmp;

    tbl[0]  = '{1'b1, 3'b111, {9'd3, 9'd2, 9'd1}, {3'd3, 3'd2, 3'd1}, 3'b001, 1'b0};
    tbl[1]  = '{1'b1, 3'b111, {9'd3, 9'd2, 9'd1}, {3'd3, 3'd2, 3'd1}, 3'b010, 1'b0};
    tbl[2]  = '{1'b1, 3'b111, {9'd3, 9'd2, 9'd1}, {3'd3, 3'd2, 3'd1}, 3'b100, 1'b0};
    tbl[3]  = '{1'b1, 3'b111, {9'd3, 9'd2, 9'd1}, {3'd3, 3'd2, 3'd1}, 3'b001, 1'b0};
    tbl[4]  = '{1'b1, 3'b000, 27'd0, 9'd0, 3'b000, 1'b0};
    tbl[5]  = '{1'b0, 3'b010, {9'd0, 9'd40, 9'd0}, {3'd0, 3'd2, 3'd0}, 3'b000, 1'b0};
    tbl[6]  = '{1'b1, 3'b010, {9'd0, 9'd40, 9'd0}, {3'd0, 3'd2, 3'd0}, 3'b010, 1'b0};
    tbl[7]  = '{1'b1, 3'b100, {9'd300, 9'd0, 9'd0}, {3'd1, 3'd0, 3'd0}, 3'b100, 1'b1};
    tbl[8]  = '{1'b1, 3'b100, {9'd300, 9'd0, 9'd0}, {3'd1, 3'd0, 3'd0}, 3'b000, 1'b0};
    tbl[9]  = '{1'b1, 3'b101, {9'd299, 9'd0, 9'd5}, {3'd2, 3'd0, 3'd1}, 3'b001, 1'b0};
    tbl[10] = '{1'b1, 3'b100, {9'd299, 9'd0, 9'd5}, {3'd2, 3'd0, 3'd1}, 3'b100, 1'b0};
    tbl[11] = '{1'b1, 3'b000, 27'd0, 9'd0, 3'b000, 1'b0};

    rst_n    = 1'b0;
    blank    = 1'b0;
    req      = 3'b000;
    req_addr = 27'd0;
    req_data = 9'd0;
    clr_req  = 1'b0;
    model_reset();
    #3;
    check_all("reset");
    #9;
    rst_n = 1'b1;

    // Single write of STAR to tile 21 lands in map bits [65:63].
    blank    = 1'b1;
    req      = 3'b001;
    req_addr = {9'd0, 9'd0, 9'd21};
    req_data = {3'd0, 3'd0, 3'd3};
    step("single");
    chk("single gnt", 32'(gnt), 32'b001);
    req = 3'b000;
    step("single idle");
    chk("single tile21", 32'(map[65:63]), 32'b011);
    tmp = map;
    tmp[65:63] = 3'b000;
    chk("single others zero", 32'(tmp == '0), 32'd1);

    pulse_reset("reset2");

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      blank    = tbl[i].blank;
      req      = tbl[i].req;
      req_addr = tbl[i].addr;
      req_data = tbl[i].data;
      step("table");
      chk($sformatf("table[%0d] gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("table[%0d] err_oob", i), 32'(err_oob), 32'(tbl[i].err));
    end

    // Requests wait out the visible area, then win on the first blank edge.
    blank    = 1'b0;
    req      = 3'b010;
    req_addr = {9'd0, 9'd77, 9'd0};
    req_data = {3'd0, 3'd1, 3'd0};
    for (int i = 0; i < 50; i++) begin
      step("visible");
      chk("visible no gnt", 32'(gnt), 32'd0);
    end
    blank = 1'b1;
    step("first blank");
    chk("first blank gnt", 32'(gnt), 32'b010);
    req = 3'b000;

    // Random traffic: each requester holds its request until granted.
    for (int n = 0; n < 400; n++) begin
      step("random");
      for (int k = 0; k < 3; k++) begin
        if (m_gnt[k] || !req[k]) begin
          if ($urandom_range(0, 2) != 0) begin
            req[k] = 1'b1;
            req_addr[9*k +: 9] = 9'($urandom_range(0, 319));
            req_data[3*k +: 3] = 3'($urandom_range(0, 3));
          end else begin
            req[k] = 1'b0;
          end
        end
      end
      blank = ($urandom_range(0, 9) < 7);
    end

    // Clear beats a simultaneous request, then runs 300 blank cycles.
    clr_req  = 1'b1;
    blank    = 1'b1;
    req      = 3'b001;
    req_addr = {9'd0, 9'd0, 9'd10};
    req_data = {3'd0, 3'd0, 3'd3};
    step("clr start");
    chk("clr start gnt", 32'(gnt), 32'd0);
    chk("clr start busy", 32'(clr_busy), 32'd1);
    clr_req      = 1'b0;
    n0           = 0;
    busy_samples = clr_busy ? 1 : 0;
    done_cnt     = 0;
    for (int n = 0; n < 3000 && m_busy; n++) begin
      blank   = ($urandom_range(0, 3) != 0);
      clr_req = ($urandom_range(0, 9) == 0);
      if (!blank) n0++;
      step("clearing");
      if (clr_busy) busy_samples++;
      if (clr_done) done_cnt++;
    end
    clr_req = 1'b0;
    chk("clr busy cycles", 32'(busy_samples), 32'(300 + n0));
    chk("clr done count", 32'(done_cnt), 32'd1);
    chk("clr map zero", 32'(map == '0), 32'd1);
    blank = 1'b1;
    step("after clr");
    chk("after clr gnt", 32'(gnt), 32'b001);
    req = 3'b000;
    step("after clr idle");

    // Reset in the middle of a clear discards everything.
    req      = 3'b011;
    req_addr = {9'd0, 9'd200, 9'd0};
    req_data = {3'd0, 3'd1, 3'd2};
    step("prefill a");
    step("prefill b");
    req = 3'b000;
    step("prefill c");
    clr_req = 1'b1;
    step("clr2 start");
    clr_req = 1'b0;
    for (int i = 0; i < 150; i++) step("clr2 run");
    rst_n = 1'b0;
    #1;
    chk("midclr reset busy", 32'(clr_busy), 32'd0);
    chk("midclr reset map", 32'(map == '0), 32'd1);
    model_reset();
    check_all("midclr reset");
    #2;
    rst_n = 1'b1;

    // Clear after reset starts again at tile 0.
    req      = 3'b011;
    req_addr = {9'd0, 9'd299, 9'd0};
    req_data = {3'd0, 3'd1, 3'd3};
    step("refill a");
    step("refill b");
    req = 3'b000;
    step("refill c");
    clr_req = 1'b1;
    step("clr3 start");
    clr_req = 1'b0;
    step("clr3 first");
    chk("clr3 tile0 cleared", 32'(map[2:0]), 32'd0);
    chk("clr3 tile299 kept", 32'(map[899:897]), 32'd1);
    for (int i = 0; i < 299; i++) step("clr3 run");
    chk("clr3 done", 32'(clr_done), 32'd1);
    chk("clr3 busy", 32'(clr_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/map_write_arbiter.md
MAP_WRITE_ARBITER -- requirements
Module: map_write_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: blank  in  1  high while the VGA raster is outside the 640x480 visible area.
REQ-004 SHALL have ports: req  in  3  per-requester write request, level, bit k = requester k.
REQ-005 SHALL have ports: req_addr  in  27  tile index, 9 bits per requester (k at bits [9k+8:9k]); index = h + 20*v, valid 0..299.
REQ-006 SHALL have ports: req_data  in  9  tile code, 3 bits per requester (k at [3k+2:3k]); 0 NONE, 1 LINE, 2 TERMINAL, 3 STAR.
REQ-007 SHALL have ports: gnt  out  3  one-hot, one-cycle grant pulse.
REQ-008 SHALL have ports: clr_req  in  1  pulse to start a whole-map clear.
REQ-009 SHALL have ports: clr_busy  out  1  high while clear is in progress.
REQ-010 SHALL have ports: clr_done  out  1  one-cycle pulse on clear completion.
REQ-011 SHALL have ports: err_oob  out  1  one-cycle pulse when a granted write is discarded for index >= 300.
REQ-012 SHALL have ports: map  out  900  registered tile map for the screen renderer; tile i at map[3i..3i+2], MSB first.

Function
REQ-013 SHALL implement FSM states IDLE and CLEAR; single owner of the map register.
REQ-014 IDLE, rising edge with clr_req=1: SHALL enter CLEAR, set the clear pointer to 0, and grant nothing that cycle; clr_req has priority over req.
REQ-015 IDLE, clr_req=0, blank=1: SHALL select one requester k with req[k]=1 and gnt[k]=0 by round-robin, starting from the priority pointer.
REQ-016 On selecting k: SHALL write req_data[k] to tile req_addr[k] and set gnt[k]=1 at the same edge; write is visible on map the next cycle.
REQ-017 After granting k: SHALL set the priority pointer to (k+1) mod 3; pointer SHALL be unchanged when nothing is granted.
REQ-018 blank=0: SHALL issue no grant and make no write; pending req SHALL wait, with no loss or reordering per requester.
REQ-019 Requester SHALL hold req/addr/data stable until gnt; arbiter SHALL never grant a requester whose gnt is currently high (no double write).
REQ-020 Granted index >= 300: SHALL assert gnt as normal, leave map unchanged, and pulse err_oob in the same cycle as gnt.
REQ-021 At most one tile write per cycle; gnt SHALL be zero or one-hot.
REQ-022 CLEAR: clr_busy=1; each cycle with blank=1 SHALL write NONE to tile[ptr] and increment ptr; blank=0 pauses the clear with ptr held.
REQ-023 CLEAR: the write of ptr=299 SHALL return to IDLE and pulse clr_done on that edge; clear takes exactly 300 blank cycles.
REQ-024 CLEAR: req SHALL be ignored (gnt=0) and clr_req SHALL be ignored (no restart).
REQ-025 Clear pointer SHALL be 9 bits, never exceeding 299; round-robin pointer 2 bits, values 0..2.

Reset
REQ-026 rst_n=0 SHALL immediately force: map all zeros, gnt=0, clr_busy=0, clr_done=0, err_oob=0, state IDLE, clear pointer 0, priority pointer 0.
REQ-027 Reset asserted mid-CLEAR or mid-grant SHALL abort the operation with no partial state retained; the first grant after release needs blank=1.

Verification
REQ-028 blank=1, req=3'b001, addr0=21, data0=3 -> gnt=001 next edge; map[63..65]=011; all other bits 0.
REQ-029 blank=1, req=3'b111 held, all addresses distinct -> grants 001,010,100,001 on consecutive edges; never two consecutive grants to the same requester.
REQ-030 blank=0, req=3'b010 for 50 cycles, then blank=1 -> no gnt during the 50 cycles; gnt=010 on the first blank edge.
REQ-031 map pre-filled, clr_req with req=3'b001 in the same cycle -> no gnt; clr_busy for 300 blank cycles (longer by the count of blank=0 cycles); clr_done once; map all 0; gnt=001 afterwards.
REQ-032 req=3'b100, addr2=300 -> gnt=100 and err_oob=1 in the same cycle; map unchanged.
REQ-033 rst_n=0 at clear pointer=150 -> map zero, clr_busy=0 immediately; after release, clr_req restarts the clear from tile 0.
